// File: rtl/nand_sweep_ctrl.sv
// nand_sweep_ctrl
// ---------------------------------------------------------------------------
// Drives one 2-input gate through its truth table, {A,B} = 00, 01, 10, 11.
// Each vector is held for SETTLE cycles and then sampled for one cycle. The
// four samples form a truth table that is compared with EXPECT.
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a sweep (sampled only while idle)
//   abort      : cancel a sweep while settling or sampling
//   y          : output of the gate under control
//   a, b       : gate inputs (registered)
//   busy       : high while a sweep is in progress, including the done cycle
//   done       : one-cycle pulse at the end of a completed sweep
//   table_out  : captured truth table, bit index {A,B}
//   pass       : table_out == EXPECT, valid from done until the next start
//   fail_mask  : table_out ^ EXPECT, valid from done until the next start
//
// All outputs are registered, so there is no combinational path from y to
// any output.
// ---------------------------------------------------------------------------
module nand_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic [3:0] table_out,
  output logic       pass,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Last settle count before moving to SAMPLE.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] table_q, table_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_mask_q, fail_mask_d;
  logic [3:0] cap_s;

  // Difference between the captured and the expected table.
  function automatic logic [3:0] diff_mask(input logic [3:0] tbl, input logic [3:0] exp_tbl);
    return tbl ^ exp_tbl;
  endfunction

  // Next-state, next-vector and result computation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    table_d     = table_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    cap_s       = table_q;

    case (state_q)
      ST_IDLE: begin
        a_d    = 1'b0;
        b_d    = 1'b0;
        busy_d = 1'b0;
        if (start && !abort) begin
          // Vector 00 is driven from the accepting edge; old results clear.
          state_d     = ST_SETTLE;
          idx_d       = 2'd0;
          cnt_d       = 8'd0;
          busy_d      = 1'b1;
          table_d     = 4'd0;
          pass_d      = 1'b0;
          fail_mask_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d     = ST_IDLE;
          idx_d       = 2'd0;
          cnt_d       = 8'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b0;
          table_d     = 4'd0;
          pass_d      = 1'b0;
          fail_mask_d = 4'd0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // The sample in flight is dropped along with earlier results.
          state_d     = ST_IDLE;
          idx_d       = 2'd0;
          cnt_d       = 8'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          busy_d      = 1'b0;
          table_d     = 4'd0;
          pass_d      = 1'b0;
          fail_mask_d = 4'd0;
        end else begin
          cap_s        = table_q;
          cap_s[idx_q] = y;
          table_d      = cap_s;
          cnt_d        = 8'd0;
          if (idx_q == 2'd3) begin
            // Verdict is computed from the completed table so it is valid
            // in the same cycle as done.
            state_d     = ST_DONE;
            a_d         = 1'b0;
            b_d         = 1'b0;
            done_d      = 1'b1;
            pass_d      = (cap_s == EXPECT);
            fail_mask_d = diff_mask(cap_s, EXPECT);
          end else begin
            state_d    = ST_SETTLE;
            idx_d      = idx_q + 2'd1;
            {a_d, b_d} = idx_q + 2'd1;
          end
        end
      end

      ST_DONE: begin
        // abort is ignored here; the sweep already completed.
        state_d = ST_IDLE;
        idx_d   = 2'd0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = ST_IDLE;
        idx_d       = 2'd0;
        cnt_d       = 8'd0;
        a_d         = 1'b0;
        b_d         = 1'b0;
        busy_d      = 1'b0;
        table_d     = 4'd0;
        pass_d      = 1'b0;
        fail_mask_d = 4'd0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 8'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      table_q     <= 4'd0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      table_q     <= table_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign table_out = table_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_nand_sweep_ctrl.sv
// Bench for nand_sweep_ctrl: DUT 0 uses SETTLE=2, DUT 1 uses SETTLE=1.
// Each DUT's y comes from a bench-chosen truth table indexed by {a,b}.
module tb_nand_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start_v, abort_v, y_v;
  logic [3:0] tt_v [2];
  logic [1:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [3:0] tbl_o [2];
  logic [3:0] fm_o [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural gate under control for each DUT.
  always_comb begin
    y_v[0] = tt_v[0][{a_o[0], b_o[0]}];
    y_v[1] = tt_v[1][{a_o[1], b_o[1]}];
  end

  nand_sweep_ctrl #(.SETTLE(2), .EXPECT(4'b0111)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .y(y_v[0]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .table_out(tbl_o[0]), .pass(pass_o[0]), .fail_mask(fm_o[0]));

  nand_sweep_ctrl #(.SETTLE(1), .EXPECT(4'b0111)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .y(y_v[1]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .table_out(tbl_o[1]), .pass(pass_o[1]), .fail_mask(fm_o[1]));

  // Cycles per vector: SETTLE + 1.
  function automatic int per(input int d);
    return (d == 0) ? 3 : 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_v = 2'b00;
    abort_v = 2'b00;
    tt_v[0] = 4'b0111;
    tt_v[1] = 4'b0111;
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({a_o[d], b_o[d], busy_o[d], done_o[d], pass_o[d]} !== 5'b0 ||
          tbl_o[d] !== 4'd0 || fm_o[d] !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ab=%b%b busy=%b done=%b tbl=%b pass=%b fm=%b, required all 0",
                 d, a_o[d], b_o[d], busy_o[d], done_o[d], tbl_o[d], pass_o[d], fm_o[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Full sweep on DUT d with gate table tt, checked every cycle against
  // the timing rules: vector k = j/P while j < 4P, done at j = 4P.
  task automatic test_sweep(input int d, input logic [3:0] tt, input bit mid_start, input bit abort_done);
    int p;
    logic [1:0] e_ab;
    logic [3:0] e_tbl, e_fm;
    logic e_busy, e_done, e_pass;
    p = per(d);
    tt_v[d] = tt;
    start_v[d] = 1'b1;
    step();
    start_v[d] = 1'b0;
    for (int j = 0; j <= 4 * p + 1; j++) begin
      if (j < 4 * p) begin
        e_ab   = 2'(j / p);
        e_tbl  = tt & 4'((1 << (j / p)) - 1);
        e_busy = 1'b1;
        e_done = 1'b0;
        e_pass = 1'b0;
        e_fm   = 4'd0;
      end else begin
        e_ab   = 2'd0;
        e_tbl  = tt;
        e_busy = (j == 4 * p);
        e_done = (j == 4 * p);
        e_pass = (tt == 4'b0111);
        e_fm   = tt ^ 4'b0111;
      end
      n_tests++;
      if ({a_o[d], b_o[d]} !== e_ab) begin
        n_fail++;
        $display("FAIL sweep_ab dut%0d j=%0d: got %b%b, required %b", d, j, a_o[d], b_o[d], e_ab);
      end
      n_tests++;
      if (busy_o[d] !== e_busy || done_o[d] !== e_done) begin
        n_fail++;
        $display("FAIL sweep_busy_done dut%0d j=%0d: got busy=%b done=%b, required busy=%b done=%b",
                 d, j, busy_o[d], done_o[d], e_busy, e_done);
      end
      n_tests++;
      if (tbl_o[d] !== e_tbl || pass_o[d] !== e_pass || fm_o[d] !== e_fm) begin
        n_fail++;
        $display("FAIL sweep_result dut%0d j=%0d tt=%b: got tbl=%b pass=%b fm=%b, required tbl=%b pass=%b fm=%b",
                 d, j, tt, tbl_o[d], pass_o[d], fm_o[d], e_tbl, e_pass, e_fm);
      end
      // Extra start pulses while busy (SETTLE and DONE) and an abort in DONE
      // must all be ignored.
      start_v[d] = mid_start && (j == p + 1 || j == 4 * p);
      abort_v[d] = abort_done && (j == 4 * p);
      if (j < 4 * p + 1) step();
    end
    start_v[d] = 1'b0;
    abort_v[d] = 1'b0;
  endtask

  task automatic test_abort();
    int p, jab;
    p = per(0);
    jab = $urandom_range(3 * p - 1, 2 * p);
    tt_v[0] = 4'b0111;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int j = 0; j < jab; j++) step();
    n_tests++;
    if ({a_o[0], b_o[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL abort_pre_ab: got %b%b, required 10", a_o[0], b_o[0]);
    end
    abort_v[0] = 1'b1;
    step();
    abort_v[0] = 1'b0;
    n_tests++;
    if ({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0]} !== 5'b0 ||
        tbl_o[0] !== 4'd0 || fm_o[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_idle: ab=%b%b busy=%b done=%b tbl=%b pass=%b fm=%b, required all 0",
               a_o[0], b_o[0], busy_o[0], done_o[0], tbl_o[0], pass_o[0], fm_o[0]);
    end
    for (int j = 0; j < 4 * p + 2; j++) begin
      step();
      n_tests++;
      if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet j=%0d: got done=%b busy=%b, required 0 0", j, done_o[0], busy_o[0]);
      end
    end
    test_sweep(0, 4'b0111, 1'b0, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    logic [3:0] held_tbl;
    held_tbl = tt_v[0];
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    step();
    n_tests++;
    if (busy_o[0] !== 1'b0 || tbl_o[0] !== held_tbl || fm_o[0] !== (held_tbl ^ 4'b0111)) begin
      n_fail++;
      $display("FAIL start_abort_idle: got busy=%b tbl=%b fm=%b, required busy=0 tbl=%b fm=%b",
               busy_o[0], tbl_o[0], fm_o[0], held_tbl, held_tbl ^ 4'b0111);
    end
    // abort alone in IDLE leaves results untouched.
    abort_v[0] = 1'b1;
    step();
    abort_v[0] = 1'b0;
    n_tests++;
    if (tbl_o[0] !== held_tbl || busy_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_idle: got tbl=%b busy=%b, required tbl=%b busy=0", tbl_o[0], busy_o[0], held_tbl);
    end
  endtask

  task automatic test_reset_mid();
    int p;
    p = per(0);
    tt_v[0] = 4'b0111;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    for (int j = 0; j < p + 1; j++) step();
    n_tests++;
    if ({a_o[0], b_o[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_pre_ab: got %b%b, required 01", a_o[0], b_o[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_o[0], b_o[0], busy_o[0], done_o[0], pass_o[0]} !== 5'b0 ||
        tbl_o[0] !== 4'd0 || fm_o[0] !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: ab=%b%b busy=%b done=%b tbl=%b pass=%b fm=%b, required all 0",
               a_o[0], b_o[0], busy_o[0], done_o[0], tbl_o[0], pass_o[0], fm_o[0]);
    end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: got done=%b busy=%b, required 0 0", done_o[0], busy_o[0]);
    end
    test_sweep(0, 4'b0111, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] tt;
    for (int i = 0; i < 8; i++) begin
      tt = 4'($urandom_range(15, 0));
      test_sweep(i % 2, tt, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      step();
    end
  endtask

  initial begin
    test_reset();
    test_sweep(0, 4'b0111, 1'b0, 1'b0);      // NAND
    step();
    test_sweep(0, 4'b1111, 1'b0, 1'b0);      // y stuck at 1
    step();
    test_sweep(0, 4'b1000, 1'b0, 1'b0);      // AND gate
    test_sweep(0, 4'b0111, 1'b1, 1'b1);      // back-to-back, ignored start/abort
    test_start_abort_idle();
    test_abort();
    test_reset_mid();
    step();
    test_sweep(1, 4'b0111, 1'b0, 1'b0);      // SETTLE=1
    test_sweep(1, 4'b0110, 1'b1, 1'b0);
    step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
